muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer for the HI/LO arithmetic resource in the EX stage: executes MULT/MULTU over a fixed multi-cycle latency and DIV/DIVU with a 1-bit-per-cycle restoring divider.
- Holds the pipeline via a stall output while busy.
- Delivers the 64-bit result to the HI/LO write path with a one-cycle valid pulse.
- Supports cancellation by an exception flush.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (range 1..8).
- DIV_ITER, 32, divider iterations (fixed at operand width).

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- md_valid  in  1  EX-stage instruction is a mult/div; held high while stall_o=1
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (dividend / multiplicand)
- src_b  in  32  rt operand (divisor / multiplier)
- cancel  in  1  exception flush of EX stage; aborts the operation in flight
- stall_o  out  1  pipeline hold request
- busy_o  out  1  FSM not in IDLE
- result_valid  out  1  one-cycle pulse: hi_o/lo_o updated this cycle
- hi_o  out  32  MULT: product[63:32]; DIV: remainder
- lo_o  out  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset state (resetn=0, asynchronous): FSM=IDLE, stall_o=0, busy_o=0, result_valid=0, hi_o=0, lo_o=0, iteration counter=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - stall_o = md_valid & ~cancel (combinational).
  - On an edge with md_valid=1 and cancel=0, latch operands and md_op.
  - md_op[1]=0 goes to MUL with counter=MUL_LAT-1; md_op[1]=1 goes to DIV with counter=0.
- MUL:
  - Product is computed from the latched operands: signed 32x32->64 for MULT, unsigned for MULTU.
  - Counter decrements each cycle; leave for DONE when counter=0.
  - Result is valid MUL_LAT+1 cycles after the accept cycle.
- DIV:
  - Operates on absolute values for DIV, raw values for DIVU.
  - Each cycle shifts one dividend bit into the partial remainder. If remainder >= divisor: subtract and set quotient bit, else clear it.
  - After DIV_ITER cycles go to DONE.
  - DIV sign fix in DONE: quotient negated if src_a[31]^src_b[31]; remainder takes the sign of src_a. Truncation toward zero.
  - Example: -7/2 gives q=-3, r=-1.
- Divide by zero (src_b=0, either div op):
  - Skip iteration; DIV goes to DONE after 1 cycle.
  - lo_o=32'hFFFFFFFF, hi_o=src_a (latched), regardless of sign.
- DONE:
  - result_valid=1, hi_o/lo_o registered on entry, stall_o=0, busy_o=1.
  - md_valid is ignored in this cycle, because the same instruction is still in EX.
  - Next state is always IDLE.
- busy_o = (state != IDLE); stall_o = 1 in MUL and DIV.
- Cancel:
  - In MUL or DIV: next state IDLE, no result_valid, hi_o/lo_o unchanged, stall_o drops the same cycle (combinational on cancel).
  - In DONE: ignored; the result was already committed.
  - cancel with md_valid in IDLE: no accept.
- hi_o/lo_o hold their value between operations.
- Latency, counting the accept cycle as cycle 0:
  - DIV/DIVU: result_valid in cycle DIV_ITER+1 = 33.
  - MULT/MULTU: result_valid in cycle MUL_LAT+1 = 3.
  - Divide by zero: result_valid in cycle 2.
- Reset asserted mid-operation returns to the reset state immediately; no result is produced.

Optional Feature:
- Macro: MULDIV_EARLY_EN.
- Defined: in DIV, if |dividend| < |divisor| (unsigned compare for DIVU) and divisor != 0, skip iteration. Go to DONE after 1 cycle with quotient=0 and remainder=dividend (sign preserved).
- Also defined: if dividend=0, same path.
- Undefined: all nonzero-divisor divides take exactly DIV_ITER iterations.
- Result values are identical either way; only latency differs.

Test Plan:
- MULTU src_a=32'hFFFFFFFF, src_b=2 -> result_valid in cycle 3; hi_o=1, lo_o=32'hFFFFFFFE; stall_o=1 cycles 0-2, 0 in cycle 3.
- MULT src_a=-3, src_b=5 -> hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFF1.
- DIV src_a=-7, src_b=2 -> result_valid in cycle 33; lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF. DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU src_a=32'h12345678, src_b=0 -> result_valid in cycle 2; lo_o=32'hFFFFFFFF, hi_o=32'h12345678.
- DIV 1000/3 with cancel pulsed in cycle 10 -> state IDLE in cycle 11, stall_o=0 in cycle 10, no result_valid, hi_o/lo_o keep previous values. A new DIVU 9/4 accepted afterwards gives lo_o=2, hi_o=1.
- resetn low in cycle 15 of a DIV -> all outputs 0 immediately. With MULDIV_EARLY_EN, DIV 3/10 gives result_valid in cycle 2, lo_o=0, hi_o=3.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency MULT/MULTU and a restoring 1-bit/cycle divider.
// Optional macro MULDIV_EARLY_EN lets trivial divides (|a| < |b| or a == 0) finish in one cycle.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] dvd_q, dvd_d;  // dividend shifts out the top, quotient shifts in the bottom
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        stall;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh, diff;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt, q_fix, r_fix;

  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  // Sign-extending both operands to 64 bits gives the signed product in the low 64 bits.
  assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

  always_comb begin
    abs_a   = abs_val(a_q, sgn_q);
    abs_b   = abs_val(b_q, sgn_q);
    rem_sh  = {rem_q, dvd_q[31]};
    diff    = rem_sh - {1'b0, abs_b};
    ge      = ~diff[32];
    rem_nxt = ge ? diff[31:0] : rem_sh[31:0];
    quo_nxt = {dvd_q[30:0], ge};
    q_fix   = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
    r_fix   = (sgn_q && a_q[31]) ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall = md_valid & ~cancel;
        if (md_valid && !cancel) begin
          sgn_d = ~md_op[0];
          a_d   = src_a;
          b_d   = src_b;
          dvd_d = abs_val(src_a, ~md_op[0]);
          rem_d = '0;
          if (md_op[1]) begin
            state_d = StDiv;
            cnt_d   = '0;
          end else begin
            state_d = StMul;
            cnt_d   = 5'(MUL_LAT - 1);
          end
        end
      end

      StMul: begin
        stall = ~cancel;
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StDone;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      StDiv: begin
        stall = ~cancel;
        if (cancel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (b_q == '0) begin
          state_d = StDone;
          hi_d    = a_q;
          lo_d    = '1;
`ifdef MULDIV_EARLY_EN
        end else if (cnt_q == '0 && (abs_a < abs_b || a_q == '0)) begin
          state_d = StDone;
          hi_d    = a_q;
          lo_d    = '0;
`endif
        end else begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          if (cnt_q == 5'(DIV_ITER - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
            hi_d    = r_fix;
            lo_d    = q_fix;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Held low while reset is asserted so a pending md_valid cannot request a stall.
  assign stall_o      = stall & resetn;
  assign busy_o       = (state_q != StIdle);
  assign result_valid = (state_q == StDone);
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus hand-written cancel/reset sequences.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        md_valid;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stall_o, busy_o, result_valid;
  logic [31:0] hi_o, lo_o;

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;
`ifdef MULDIV_EARLY_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 33;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  vec_t        vecs[16];
  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .md_valid     (md_valid),
    .md_op        (md_op),
    .src_a        (src_a),
    .src_b        (src_b),
    .cancel       (cancel),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int divu_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
    if (a < b || a == 0) return EarlyLat;
    return 33;
  endfunction

  // Drive one operation from the accept cycle (cycle 0) and compare when result_valid appears.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    exp_t e;
    int   cyc;
    bit   got, stall_ok;
    e.hi = ehi; e.lo = elo; e.lat = lat;
    exp_q.push_back(e);
    md_valid = 1'b1; md_op = op; src_a = a; src_b = b;
    #1;
    stall_ok = (stall_o === 1'b1);
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      step();
      cyc++;
      if (result_valid === 1'b1) begin
        got = 1;
        md_valid = 1'b0;
        e = exp_q.pop_front();
        check({name, " hi"}, hi_o, e.hi);
        check({name, " lo"}, lo_o, e.lo);
        check({name, " latency"}, cyc, e.lat);
        check({name, " stall_done"}, {31'd0, stall_o}, 32'd0);
        last_hi = e.hi; last_lo = e.lo;
      end else if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
        stall_ok = 0;
      end
    end
    if (!got) begin
      md_valid = 1'b0;
      check({name, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check({name, " stall_held"}, {31'd0, stall_ok}, 32'd1);
    step();
  endtask

  initial begin
    bit          rv_seen;
    logic [31:0] ra, rb;
    logic [63:0] p;

    vecs[0]  = '{OpMultu, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 3};
    vecs[1]  = '{OpMult,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 3};
    vecs[2]  = '{OpMult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        3};
    vecs[3]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        3};
    vecs[4]  = '{OpMult,  32'h80000000, 32'd7,        32'hFFFFFFFC, 32'h80000000, 3};
    vecs[5]  = '{OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[6]  = '{OpDivu,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[7]  = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[8]  = '{OpDiv,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33};
    vecs[9]  = '{OpDivu,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 2};
    vecs[10] = '{OpDiv,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 2};
    vecs[11] = '{OpDivu,  32'd3,        32'd10,       32'd3,        32'd0,        EarlyLat};
    vecs[12] = '{OpDiv,   32'hFFFFFFFD, 32'd10,       32'hFFFFFFFD, 32'd0,        EarlyLat};
    vecs[13] = '{OpDiv,   32'd0,        32'd5,        32'd0,        32'd0,        EarlyLat};
    vecs[14] = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
    vecs[15] = '{OpDivu,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};

    resetn = 1'b0; md_valid = 1'b0; md_op = '0; src_a = '0; src_b = '0; cancel = 1'b0;
    #2;
    check("reset stall", {31'd0, stall_o}, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset valid", {31'd0, result_valid}, 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    step();
    resetn = 1'b1;
    step();

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      p  = {32'd0, ra} * {32'd0, rb};
      run_op($sformatf("rnd_multu%0d", i), OpMultu, ra, rb, p[63:32], p[31:0], 3);
      rb = $urandom_range(1, 1000);
      run_op($sformatf("rnd_divu%0d", i), OpDivu, ra, rb, ra % rb, ra / rb, divu_lat(ra, rb));
    end

    // Cancel a DIV in cycle 10.
    md_valid = 1'b1; md_op = OpDiv; src_a = 32'd1000; src_b = 32'd3;
    rv_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (result_valid === 1'b1) rv_seen = 1;
    end
    cancel = 1'b1;
    #1;
    check("cancel stall_drop", {31'd0, stall_o}, 32'd0);
    check("cancel busy_c10", {31'd0, busy_o}, 32'd1);
    step();
    if (result_valid === 1'b1) rv_seen = 1;
    check("cancel idle_c11", {31'd0, busy_o}, 32'd0);
    check("cancel no_valid", {31'd0, rv_seen}, 32'd0);
    check("cancel hi_kept", hi_o, last_hi);
    check("cancel lo_kept", lo_o, last_lo);
    cancel = 1'b0; md_valid = 1'b0;
    step();
    run_op("divu_after_cancel", OpDivu, 32'd9, 32'd4, 32'd1, 32'd2, divu_lat(32'd9, 32'd4));

    // Reset in cycle 15 of a DIV.
    md_valid = 1'b1; md_op = OpDiv; src_a = 32'd1000; src_b = 32'd3;
    for (int c = 1; c <= 15; c++) step();
    resetn = 1'b0;
    #1;
    check("midreset stall", {31'd0, stall_o}, 32'd0);
    check("midreset busy", {31'd0, busy_o}, 32'd0);
    check("midreset valid", {31'd0, result_valid}, 32'd0);
    check("midreset hi", hi_o, 32'd0);
    check("midreset lo", lo_o, 32'd0);
    md_valid = 1'b0;
    step();
    resetn = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (result_valid === 1'b1 || busy_o === 1'b1) rv_seen = 1;
    end
    check("midreset no_result", {31'd0, rv_seen}, 32'd0);

    // Cancel together with md_valid in IDLE must not accept.
    md_valid = 1'b1; md_op = OpMult; src_a = 32'd3; src_b = 32'd4; cancel = 1'b1;
    #1;
    check("idle_cancel stall", {31'd0, stall_o}, 32'd0);
    step();
    check("idle_cancel busy", {31'd0, busy_o}, 32'd0);
    md_valid = 1'b0; cancel = 1'b0;
    step();
    run_op("mult_final", OpMult, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
